// File: rtl/buslogic_pkg.sv
// Shared port-size / DSACK encodings and the bus-cycle state type for the
// k30p local-bus logic.
package buslogic_pkg;

  localparam logic [1:0] PORT_32  = 2'b00;
  localparam logic [1:0] PORT_16  = 2'b01;
  localparam logic [1:0] PORT_8   = 2'b10;
  localparam logic [1:0] PORT_EXT = 2'b11;

  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_IDLE = 2'b11;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXTERNAL,
    S_ACK,
    S_BERR
  } state_t;

  function automatic logic [1:0] port_dsack(input logic [1:0] port);
    logic [1:0] code;
    case (port)
      PORT_32: code = DSACK_32;
      PORT_16: code = DSACK_16;
      PORT_8:  code = DSACK_8;
      default: code = DSACK_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle timeout counter: runs while enabled, flags expiry on the cycle the
// count reaches TIMEOUT_CYCLES; TIMEOUT_CYCLES = 0 disables it entirely.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic expired
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  localparam int unsigned LAST = ENABLED ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TIMEOUT_WIDTH-1:0] LAST_V = LAST[TIMEOUT_WIDTH-1:0];

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable || !ENABLED) begin
      count <= '0;
    end else if (count != LAST_V) begin
      count <= count + 1'b1;
    end
  end

  // The Nth enabled edge is the one that sees count == N-1.
  assign expired = ENABLED && enable && (count == LAST_V);

endmodule

// File: rtl/bus_cycle_controller.sv
// Local-bus cycle terminator: per-region wait states and port size, external
// acknowledge pass-through, BERR watchdog and CPU clock divider.
module bus_cycle_controller
  import buslogic_pkg::*;
#(
  parameter int unsigned NUM_REGIONS    = 4,
  parameter int unsigned WAIT_WIDTH     = 4,
  parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] REGION_WAITS = '0,
  parameter logic [NUM_REGIONS*2-1:0]          REGION_PORT  = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8,
  parameter int unsigned CLOCK_DIV_LOG2 = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_as,
  input  logic [NUM_REGIONS-1:0] region_request,
  input  logic [1:0]             external_dsack,
  input  logic                   timeout_clear,
  output logic                   cpu_clock,
  output logic [1:0]             cpu_dsack_out,
  output logic                   cpu_berr_out,
  output logic                   timeout_flag,
  output logic [2:0]             active_region
);

  state_t                    state;
  logic                      as_q;
  logic [WAIT_WIDTH-1:0]     wait_cnt;
  logic [1:0]                ack_code;
  logic                      no_region;
  logic [CLOCK_DIV_LOG2-1:0] div_cnt;
  logic                      wd_enable;
  logic                      expired;

  logic                  hit;
  logic [2:0]            sel_idx;
  logic [WAIT_WIDTH-1:0] sel_wait;
  logic [1:0]            sel_port;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) as_q <= INACTIVE;
    else        as_q <= cpu_as;
  end

  // Scan high to low so the lowest active index is the last one written.
  always_comb begin
    hit      = 1'b0;
    sel_idx  = '0;
    sel_wait = '0;
    sel_port = PORT_32;
    for (int unsigned i = NUM_REGIONS; i > 0; i--) begin
      if (region_request[i-1] == ACTIVE) begin
        hit      = 1'b1;
        sel_idx  = 3'(i - 1);
        sel_wait = REGION_WAITS[(i-1)*WAIT_WIDTH +: WAIT_WIDTH];
        sel_port = REGION_PORT[(i-1)*2 +: 2];
      end
    end
  end

  assign wd_enable = (state == S_WAIT) || (state == S_EXTERNAL);

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .enable  (wd_enable),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cpu_dsack_out <= DSACK_IDLE;
      cpu_berr_out  <= INACTIVE;
      timeout_flag  <= 1'b0;
      active_region <= '0;
      wait_cnt      <= '0;
      ack_code      <= DSACK_IDLE;
      no_region     <= 1'b0;
    end else begin
      if (timeout_clear) timeout_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          cpu_dsack_out <= DSACK_IDLE;
          cpu_berr_out  <= INACTIVE;
          if (as_q == ACTIVE) begin
            if (hit) begin
              active_region <= sel_idx;
              no_region     <= 1'b0;
              if (sel_port == PORT_EXT) begin
                state <= S_EXTERNAL;
              end else begin
                wait_cnt <= sel_wait;
                ack_code <= port_dsack(sel_port);
                state    <= S_WAIT;
              end
            end else begin
              no_region <= 1'b1;
              state     <= S_EXTERNAL;
            end
          end
        end
        S_WAIT: begin
          if (as_q == INACTIVE) begin
            state <= S_IDLE;
          end else if (wait_cnt == '0) begin
            state <= S_ACK;
          end else if (expired) begin
            state        <= S_BERR;
            timeout_flag <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_EXTERNAL: begin
          // An acknowledge arriving on the expiry cycle takes precedence.
          if (as_q == INACTIVE) begin
            state <= S_IDLE;
          end else if (!no_region && external_dsack != DSACK_IDLE) begin
            ack_code <= external_dsack;
            state    <= S_ACK;
          end else if (expired) begin
            state        <= S_BERR;
            timeout_flag <= 1'b1;
          end
        end
        S_ACK: begin
          cpu_dsack_out <= ack_code;
          if (as_q == INACTIVE) state <= S_IDLE;
        end
        S_BERR: begin
          cpu_dsack_out <= DSACK_IDLE;
          cpu_berr_out  <= ACTIVE;
          if (as_q == INACTIVE) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      cpu_clock <= 1'b0;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      cpu_clock <= div_cnt[CLOCK_DIV_LOG2-1];
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Scoreboard bench for bus_cycle_controller: stimulus queues expected output
// changes with their cycle numbers, a negedge monitor pops and compares them.
module tb_bus_cycle_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_as = 1'b1;
  logic [3:0] region_request = 4'hF;
  logic [1:0] external_dsack = 2'b11;
  logic       timeout_clear = 1'b0;
  logic       cpu_clock;
  logic [1:0] cpu_dsack_out;
  logic       cpu_berr_out;
  logic       timeout_flag;
  logic [2:0] active_region;

  // r0: 32-bit 0 waits, r1: 16-bit 2 waits, r2: 8-bit 5 waits, r3: external
  bus_cycle_controller #(
    .NUM_REGIONS    (4),
    .WAIT_WIDTH     (4),
    .REGION_WAITS   (16'h0520),
    .REGION_PORT    (8'b11_10_01_00),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_WIDTH  (8),
    .CLOCK_DIV_LOG2 (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_as         (cpu_as),
    .region_request (region_request),
    .external_dsack (external_dsack),
    .timeout_clear  (timeout_clear),
    .cpu_clock      (cpu_clock),
    .cpu_dsack_out  (cpu_dsack_out),
    .cpu_berr_out   (cpu_berr_out),
    .timeout_flag   (timeout_flag),
    .active_region  (active_region)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] dsack;
    logic       berr;
    logic       flag;
    logic [2:0] region;
  } event_t;

  event_t     exp_q[$];
  event_t     got;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev;
  logic       exp_flag = 1'b0;
  logic [2:0] exp_region = 3'd0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_out(input int at, input logic [1:0] ds, input logic be);
    event_t e;
    e.at = at; e.dsack = ds; e.berr = be; e.flag = exp_flag; e.region = exp_region;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (mon_en && {cpu_dsack_out, cpu_berr_out, timeout_flag} != prev) begin
      prev = {cpu_dsack_out, cpu_berr_out, timeout_flag};
      check("dsack_berr_exclusive", int'(cpu_dsack_out != 2'b11 && !cpu_berr_out), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output cycle=%0d dsack=%b berr=%b flag=%b required=no_change",
                 cyc, cpu_dsack_out, cpu_berr_out, timeout_flag);
      end else begin
        got = exp_q.pop_front();
        check("event_cycle",   cyc,                got.at);
        check("event_dsack",   int'(cpu_dsack_out), int'(got.dsack));
        check("event_berr",    int'(cpu_berr_out),  int'(got.berr));
        check("event_flag",    int'(timeout_flag),  int'(got.flag));
        check("event_region",  int'(active_region), int'(got.region));
      end
    end
  end

  // Edge e: cpu_as driven; e+1: as_q low; e+2: FSM decides; dsack at e+W+4.
  task automatic run_internal(input logic [3:0] req, input logic [1:0] code,
                              input int waits, input logic [2:0] region, input int hold);
    int e, r;
    @(negedge clock);
    region_request = req; e = cyc; cpu_as = 1'b0; exp_region = region;
    expect_out(e + waits + 4, code, 1'b1);
    repeat (waits + 4 + hold) @(negedge clock);
    r = cyc; cpu_as = 1'b1;
    expect_out(r + 3, 2'b11, 1'b1);
    repeat (6) @(negedge clock);
    region_request = 4'hF;
  endtask

  initial begin
    int e, r, x, k;
    int rise1, rise2, fall;
    logic last_c;

    repeat (3) @(negedge clock);
    check("reset_dsack",     int'(cpu_dsack_out), 3);
    check("reset_berr",      int'(cpu_berr_out),  1);
    check("reset_flag",      int'(timeout_flag),  0);
    check("reset_region",    int'(active_region), 0);
    check("reset_cpu_clock", int'(cpu_clock),     0);
    reset = 1'b1;
    prev = {2'b11, 1'b1, 1'b0};
    mon_en = 1'b1;
    repeat (4) @(negedge clock);

    run_internal(4'b1110, 2'b00, 0, 3'd0, 3);

    // No region selected: BERR after the 16-cycle watchdog, sticky flag
    @(negedge clock);
    region_request = 4'hF; e = cyc; cpu_as = 1'b0;
    exp_flag = 1'b1;
    expect_out(e + 18, 2'b11, 1'b1);
    expect_out(e + 19, 2'b11, 1'b0);
    repeat (25) @(negedge clock);
    r = cyc; cpu_as = 1'b1;
    expect_out(r + 3, 2'b11, 1'b1);
    repeat (10) @(negedge clock);
    timeout_clear = 1'b1; x = cyc; exp_flag = 1'b0;
    expect_out(x + 1, 2'b11, 1'b1);
    @(negedge clock);
    timeout_clear = 1'b0;
    repeat (3) @(negedge clock);

    rise1 = -1; rise2 = -1; fall = -1;
    last_c = cpu_clock;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (!last_c && cpu_clock) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      if (last_c && !cpu_clock && rise1 >= 0 && fall < 0) fall = cyc;
      last_c = cpu_clock;
    end
    check("cpu_clock_period", rise2 - rise1, 4);
    check("cpu_clock_high",   fall - rise1,  2);

    run_internal(4'b1011, 2'b10, 5, 3'd2, 2);

    // External acknowledge on region 3, ten cycles into the cycle
    @(negedge clock);
    region_request = 4'b0111; e = cyc; cpu_as = 1'b0; exp_region = 3'd3;
    repeat (10) @(negedge clock);
    x = cyc; external_dsack = 2'b01;
    expect_out(x + 2, 2'b01, 1'b1);
    repeat (3) @(negedge clock);
    external_dsack = 2'b11;
    repeat (2) @(negedge clock);
    r = cyc; cpu_as = 1'b1;
    expect_out(r + 3, 2'b11, 1'b1);
    repeat (6) @(negedge clock);
    region_request = 4'hF;

    // Regions 1 and 2 both requested: region 1 wins
    run_internal(4'b1001, 2'b01, 2, 3'd1, 1);

    // Abort during the wait states: no acknowledge may appear
    @(negedge clock);
    region_request = 4'b1011; e = cyc; cpu_as = 1'b0; exp_region = 3'd2;
    repeat (4) @(negedge clock);
    cpu_as = 1'b1;
    repeat (15) @(negedge clock);
    check("abort_pending_events", exp_q.size(), 0);
    check("abort_region", int'(active_region), 2);
    region_request = 4'hF;
    repeat (2) @(negedge clock);

    // Reset asserted while the 8-bit acknowledge is being driven
    @(negedge clock);
    region_request = 4'b1011; e = cyc; cpu_as = 1'b0; exp_region = 3'd2;
    expect_out(e + 9, 2'b10, 1'b1);
    repeat (12) @(negedge clock);
    k = cyc; exp_region = 3'd0;
    expect_out(k + 1, 2'b11, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("midack_reset_dsack",  int'(cpu_dsack_out), 3);
    check("midack_reset_berr",   int'(cpu_berr_out),  1);
    check("midack_reset_flag",   int'(timeout_flag),  0);
    check("midack_reset_region", int'(active_region), 0);
    check("midack_reset_clock",  int'(cpu_clock),     0);
    cpu_as = 1'b1; region_request = 4'hF;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
